// File: rtl/processor_gpio_bank_if.sv
// Avalon-MM slave bus bundle for the GPIO bank.
// Three-bit word address, 32-bit data, active-low write strobe.
interface processor_gpio_bank_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/processor_gpio_bank.sv
// Parametrised GPIO bank: per-bit direction, set/clear writes, synced inputs.
// Edge capture, IRQ mask and irq exist only when GPIO_EDGE_IRQ_EN is defined.
module processor_gpio_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  processor_gpio_bank_if.slave bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     oe,
  output logic                 irq
);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_CAP  = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             wr_data;
  logic             wr_dir;
  logic             wr_set;
  logic             wr_clr;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wd      = bus.writedata[WIDTH-1:0];
  assign wr_data = wr && (bus.address == A_DATA);
  assign wr_dir  = wr && (bus.address == A_DIR);
  assign wr_set  = wr && (bus.address == A_SET);
  assign wr_clr  = wr && (bus.address == A_CLR);

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.writedata};

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= RESET_VALUE;
    end else begin
      unique case (1'b1)
        wr_data: out_q <= wd;
        wr_set:  out_q <= out_q | wd;
        wr_clr:  out_q <= out_q & ~wd;
        default: out_q <= out_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_q <= '0;
    end else if (wr_dir) begin
      oe_q <= wd;
    end
  end

  assign out_port = out_q;
  assign oe       = oe_q;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  in_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_EDGE_IRQ_EN
  logic             wr_mask;
  logic             wr_cap;
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_hit;
  logic             primed;
  logic [2:0]       prime_cnt;

  assign wr_mask = wr && (bus.address == A_MASK);
  assign wr_cap  = wr && (bus.address == A_CAP);
  assign cap_clr = wr_cap ? wd : '0;

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = in_sync & ~in_prev;
      1:       edge_raw = ~in_sync & in_prev;
      default: edge_raw = in_sync ^ in_prev;
    endcase
  end

  assign edge_hit = primed ? (edge_raw & ~oe_q) : '0;

  // Priming hides the chain filling after reset release from the detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_cnt <= '0;
      primed    <= 1'b0;
    end else if (!primed) begin
      prime_cnt <= prime_cnt + 3'd1;
      if (prime_cnt == 3'(SYNC_STAGES)) begin
        primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_prev <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
    end else begin
      in_prev <= in_sync;
      if (wr_mask) begin
        mask_q <= wd;
      end
      // A new edge overrides a same-cycle write-1-clear.
      cap_q <= (cap_q & ~cap_clr) | edge_hit;
    end
  end

  assign irq = |(cap_q & mask_q);
`else
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;

  assign mask_q = '0;
  assign cap_q  = '0;
  assign irq    = 1'b0;
`endif

  logic [31:0] rd;

  always_comb begin
    rd = '0;
    case (bus.address)
      A_DATA:  rd[WIDTH-1:0] = (oe_q & out_q) | (~oe_q & in_sync);
      A_DIR:   rd[WIDTH-1:0] = oe_q;
      A_MASK:  rd[WIDTH-1:0] = mask_q;
      A_CAP:   rd[WIDTH-1:0] = cap_q;
      default: rd = '0;
    endcase
  end

  assign bus.readdata = rd;

endmodule
